font_rom_arbiter: RTL and testbench
===================================

// Module: font_rom_arbiter
// PURPOSE
//   Shares the single synchronous font ROM (11-bit addr, 8-bit row word, 1-cycle read latency)
//   among N text overlay generators (logo, status line, menu, cursor). Picks one requester per
//   cycle, drives the ROM address, and routes the returned row word back to the requester granted one cycle
//   earlier. Sits between the text-overlay blocks and the font ROM, upstream of the RGB mux.
// PARAMETERS
//   N_REQ   4   number of requesters (2..8)
//   ADDR_W  11  ROM address width {char_addr[6:0], row_addr[3:0]}
//   DATA_W  8   ROM row word width
//   CNT_W   16  width of the stall counter
// PORTS
//   clk        in   1              system/pixel clock
//   reset      in   1              asynchronous, active-high reset
//   req        in   N_REQ          request per requester; held until granted
//   req_addr   in   N_REQ*ADDR_W   flattened addresses; slice i = bits [i*ADDR_W +: ADDR_W]
//   gnt        out  N_REQ          one-hot grant, combinational in the request cycle
//   rom_addr   out  ADDR_W         address to font ROM
//   rom_data   in   DATA_W         ROM word, valid 1 cycle after rom_addr
//   rd_valid   out  N_REQ          one-hot, registered; pulses 1 cycle after gnt
//   rd_data    out  DATA_W         row word for the rd_valid requester
//   stall_cnt  out  CNT_W          saturating count of cycles with >=1 request denied
//   stall_clr  in   1              synchronous clear of stall_cnt
// BEHAVIOUR
//   - Reset (async assert, sync-safe release): rd_valid=0, rd_data=0, stall_cnt=0, rr_ptr=0,
//     pending-id register invalid. gnt=0 and rom_addr=0 while reset is high.
//   - Cycle t: if any req, exactly one gnt bit set and rom_addr=req_addr slice of the winner.
//     If no req: gnt=0, rom_addr holds its last granted value (the ROM read is harmless; no rd_valid).
//   - Cycle t+1: rd_valid[winner]=1, rd_data=rom_data. One-cycle latency, no back-pressure; the
//     requester must capture the word in that cycle.
//   - Requester may drop req in the same cycle it sees gnt, or keep it high for back-to-back reads.
//     Back-to-back grants to the same requester give one word per cycle.
//   - Stage register: pend_vld, pend_id (ID_W=clog2(N_REQ)); rd_valid = decode(pend_id) & pend_vld.
//   - stall_cnt: +1 per cycle where popcount(req)>1 (or req!=gnt); saturates at all-ones, never wraps.
//     stall_clr takes priority over increment in the same cycle (result 0).
//   - Reset mid-read: in-flight word discarded; no rd_valid after release until a new grant.
//   - req_addr of non-granted requesters is ignored; X on those slices must not reach rom_addr.
// CONFIGURATION
//   FONT_ARB_RR_EN defined: round-robin arbitration. Search starts at rr_ptr; after each grant
//     rr_ptr <= winner+1 (mod N_REQ). rr_ptr is unchanged in idle cycles.
//   FONT_ARB_RR_EN undefined: fixed priority, req[0] highest. rr_ptr logic is not built.
// STRUCTURE
//   - Shared package font_arb_pkg: ID_W function (clog2), default ADDR_W/DATA_W, and the
//     FONT_ADDR_CHAR/ROW field widths (7/4) shared with the text overlay blocks.
//   - One sub-module: arb_pick (combinational one-hot picker, inputs req + start pointer,
//     outputs one-hot gnt + binary id). Fixed priority = arb_pick with pointer tied to 0.
//   - Top: address mux, pend_vld/pend_id stage, rd_data register, stall counter, rr_ptr.
// TESTING
//   1 Reset: assert reset mid-grant with req=4'b1111 -> gnt=0, rd_valid=0, stall_cnt=0;
//     after release no rd_valid until the first new grant.
//   2 Single requester: req=4'b0100, addr2=11'h458 -> gnt=4'b0100, rom_addr=11'h458;
//     next cycle rd_valid=4'b0100, rd_data=ROM model[11'h458].
//   3 Contention, RR on: req=4'b1111 held 8 cycles -> gnt sequence 0001,0010,0100,1000,0001...;
//     stall_cnt=8. RR off: gnt=0001 for all 8 cycles.
//   4 Back-to-back: req0 held with addr changing each cycle 11'h450..11'h457 -> rd_valid0
//     8 consecutive cycles, rd_data matches the ROM words in order.
//   5 Saturation: CNT_W=4, req=4'b0011 for 20 cycles -> stall_cnt stops at 4'hF.
//     stall_clr with contention in the same cycle -> stall_cnt=0.
//   6 Idle gap: req 1-cycle pulses with 3 idle cycles between -> rd_valid only after granted
//     cycles; rr_ptr does not advance in idle cycles (RR on).

Source files
------------

// File: rtl/font_arb_pkg.sv
// font_arb_pkg: constants and helpers shared by the font ROM arbiter and the text overlay blocks.
//   FONT_ADDR_CHAR_W / FONT_ADDR_ROW_W : ROM address fields {char_addr, row_addr}
//   DEF_*                              : default arbiter geometry
//   id_w()                             : width of a binary requester id
package font_arb_pkg;

    localparam int unsigned FONT_ADDR_CHAR_W = 7;
    localparam int unsigned FONT_ADDR_ROW_W  = 4;
    localparam int unsigned DEF_ADDR_W       = FONT_ADDR_CHAR_W + FONT_ADDR_ROW_W;
    localparam int unsigned DEF_DATA_W       = 8;
    localparam int unsigned DEF_CNT_W        = 16;
    localparam int unsigned DEF_N_REQ        = 4;

    // Never returns 0 so a one-requester build still has a legal id vector.
    function automatic int unsigned id_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/font_rom_arbiter_if.sv
// font_rom_arbiter_if: request/grant, ROM and read-return bundle of the font ROM arbiter.
//   req, req_addr      : requester side requests and flattened addresses
//   gnt                : one-hot grant (combinational)
//   rom_addr, rom_data : font ROM address out / row word back (1-cycle latency)
//   rd_valid, rd_data  : returned row word and its one-hot owner
//   stall_cnt, stall_clr : contention counter and its synchronous clear
// Modport slave is the arbiter; master is the environment (requesters plus ROM).
interface font_rom_arbiter_if
    import font_arb_pkg::*;
#(
    parameter int unsigned N_REQ  = DEF_N_REQ,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) ();

    logic [N_REQ-1:0]        req;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]       rom_addr;
    logic [DATA_W-1:0]       rom_data;
    logic [N_REQ-1:0]        rd_valid;
    logic [DATA_W-1:0]       rd_data;
    logic [CNT_W-1:0]        stall_cnt;
    logic                    stall_clr;

    modport slave (
        input  req, req_addr, rom_data, stall_clr,
        output gnt, rom_addr, rd_valid, rd_data, stall_cnt
    );

    modport master (
        output req, req_addr, rom_data, stall_clr,
        input  gnt, rom_addr, rd_valid, rd_data, stall_cnt
    );

endinterface

// File: rtl/arb_pick.sv
// arb_pick: combinational one-hot picker. Scans i_req starting at index i_start (wrapping)
// and grants the first set bit.
//   i_req   : request vector
//   i_start : index searched first (tie to 0 for fixed priority, bit 0 highest)
//   o_gnt   : one-hot grant, 0 when no request
//   o_id    : binary index of the granted bit, 0 when no request
module arb_pick
    import font_arb_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned ID_W  = id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_start,
    output logic [N_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]  o_id
);

    logic        w_found;
    int unsigned w_idx;

    always_comb begin
        o_gnt   = '0;
        o_id    = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_idx = (32'(i_start) + k) % N_REQ;
            if (!w_found && i_req[w_idx]) begin
                w_found      = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_id         = ID_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/font_rom_arbiter.sv
// font_rom_arbiter: shares one synchronous font ROM among N_REQ text overlay generators.
// One requester is granted per cycle; its address goes to the ROM and the returned row word is
// routed back to it one cycle later.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : font_rom_arbiter_if.slave (req/req_addr/gnt, rom_addr/rom_data,
//                rd_valid/rd_data, stall_cnt/stall_clr)
// Build option: define FONT_ARB_RR_EN for round-robin arbitration; otherwise fixed priority
// with req[0] highest.
module font_rom_arbiter
    import font_arb_pkg::*;
#(
    parameter int unsigned N_REQ  = DEF_N_REQ,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    font_rom_arbiter_if.slave  bus
);

    localparam int unsigned ID_W = id_w(N_REQ);

    logic [N_REQ-1:0]  w_pick_gnt;
    logic [ID_W-1:0]   w_pick_id;
    logic [ID_W-1:0]   w_start;
    logic              w_any;
    logic              w_stall;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [N_REQ-1:0]  w_rd_valid;

    logic [ADDR_W-1:0] r_last_addr;
    logic              r_pend_vld;
    logic [ID_W-1:0]   r_pend_id;
    logic [DATA_W-1:0] r_rd_data;
    logic [CNT_W-1:0]  r_stall_cnt;

`ifdef FONT_ARB_RR_EN
    logic [ID_W-1:0] r_rr_ptr;

    // Pointer moves past the winner; idle cycles leave it alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (w_any) begin
            r_rr_ptr <= (w_pick_id == ID_W'(N_REQ - 1)) ? '0 : w_pick_id + ID_W'(1);
        end
    end

    assign w_start = r_rr_ptr;
`else
    assign w_start = '0;
`endif

    arb_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .i_req   (bus.req),
        .i_start (w_start),
        .o_gnt   (w_pick_gnt),
        .o_id    (w_pick_id)
    );

    assign w_any   = |bus.req;
    assign w_stall = |(bus.req & ~w_pick_gnt);

    // Only the granted slice is selected, so X on idle requesters' addresses cannot leak out.
    always_comb begin
        w_sel_addr = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_pick_gnt[i]) begin
                w_sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign bus.gnt      = reset ? '0 : w_pick_gnt;
    assign bus.rom_addr = reset ? '0 : (w_any ? w_sel_addr : r_last_addr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_addr <= '0;
            r_pend_vld  <= 1'b0;
            r_pend_id   <= '0;
        end else begin
            r_pend_vld <= w_any;
            if (w_any) begin
                r_last_addr <= w_sel_addr;
                r_pend_id   <= w_pick_id;
            end
        end
    end

    // The ROM word arrives in the return cycle; the register only holds it afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_data <= '0;
        end else if (r_pend_vld) begin
            r_rd_data <= bus.rom_data;
        end
    end

    assign bus.rd_data = r_pend_vld ? bus.rom_data : r_rd_data;

    always_comb begin
        w_rd_valid = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_rd_valid[i] = r_pend_vld && (r_pend_id == ID_W'(i));
        end
    end

    assign bus.rd_valid = w_rd_valid;

    // Clear wins over increment; saturates at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (bus.stall_clr) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// tb_font_rom_arbiter: directed bench for font_rom_arbiter (N_REQ=4, CNT_W=4 so saturation is
// reachable). Grants and ROM addresses are checked in the request cycle; expected return words
// go into a scoreboard queue tagged with the cycle they are due, and a monitor compares rd_valid
// and rd_data on every falling edge. Expectations follow FONT_ARB_RR_EN when defined.
module tb_font_rom_arbiter;

    typedef struct {
        int         due;
        logic [3:0] vld;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   cyc_n;
    logic [10:0] last_addr;
    exp_t sb_q[$];
    exp_t mon_e;

    font_rom_arbiter_if #(.N_REQ(4), .ADDR_W(11), .DATA_W(8), .CNT_W(4)) bus ();

    font_rom_arbiter #(
        .N_REQ  (4),
        .ADDR_W (11),
        .DATA_W (8),
        .CNT_W  (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [7:0] rom_fn(input logic [10:0] a);
        return a[7:0] ^ {a[10:8], a[10:6]} ^ 8'h5A;
    endfunction

    // Synchronous font ROM model.
    always @(posedge clk) bus.rom_data <= rom_fn(bus.rom_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0 && sb_q[0].due == cyc_n) begin
            mon_e = sb_q.pop_front();
            chk("rd_valid", 32'(bus.rd_valid), 32'(mon_e.vld));
            chk("rd_data", 32'(bus.rd_data), 32'(mon_e.data));
        end else if (bus.rd_valid !== 4'b0000) begin
            chk("rd_valid_unexpected", 32'(bus.rd_valid), 32'h0);
        end
    end

    // One request cycle: drive just after posedge, check at negedge, return just after posedge.
    task automatic cyc(input logic [3:0] r, input logic [3:0][10:0] a, input logic [3:0] eg,
                       input logic clr);
        logic [10:0] ea;
        exp_t        e;
        bus.req       = r;
        bus.req_addr  = a;
        bus.stall_clr = clr;
        @(negedge clk);
        chk("gnt", 32'(bus.gnt), 32'(eg));
        ea = last_addr;
        for (int i = 0; i < 4; i++) if (eg[i]) ea = a[i];
        chk("rom_addr", 32'(bus.rom_addr), 32'(ea));
        if (eg != 4'b0000) begin
            last_addr = ea;
            e.due  = cyc_n + 1;
            e.vld  = eg;
            e.data = rom_fn(ea);
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(4'b0000, '0, 4'b0000, 1'b0);
    endtask

    logic [3:0][10:0] av;
    logic [3:0]       eg;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        last_addr = '0;
        reset     = 1'b1;
        bus.req       = 4'b1111;
        bus.req_addr  = {11'h3AA, 11'h255, 11'h123, 11'h7FF};
        bus.stall_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_rom_addr", 32'(bus.rom_addr), 32'h0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'h0);
        chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'h0);
        bus.req = 4'b0000;
        reset   = 1'b0;

        // Contention, four requesters for 8 cycles.
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 4; j++) av[j] = 11'(11'h100 + 16 * i + j);
`ifdef FONT_ARB_RR_EN
            eg = 4'b0001 << (i % 4);
`else
            eg = 4'b0001;
`endif
            cyc(4'b1111, av, eg, 1'b0);
        end
        idle();
        chk("stall_after_contention", 32'(bus.stall_cnt), 32'd8);

        // Single requester, other address slices unknown.
        av = {11'hxxx, 11'h458, 11'hxxx, 11'hxxx};
        cyc(4'b0100, av, 4'b0100, 1'b0);
        idle();
        idle();

        // Back-to-back reads by requester 0.
        for (int i = 0; i < 8; i++) begin
            av = {11'h0, 11'h0, 11'h0, 11'(11'h450 + i)};
            cyc(4'b0001, av, 4'b0001, 1'b0);
        end
        idle();

        // One-cycle pulses separated by idle gaps; pointer must hold through the gaps.
        for (int p = 0; p < 3; p++) begin
            av = {11'(11'h600 + p), 11'h0, 11'(11'h500 + p), 11'h0};
`ifdef FONT_ARB_RR_EN
            eg = (p == 1) ? 4'b1000 : 4'b0010;
`else
            eg = 4'b0010;
`endif
            cyc(4'b1010, av, eg, 1'b0);
            repeat (3) idle();
        end

        // Saturation of the 4-bit stall counter.
        cyc(4'b0000, '0, 4'b0000, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if (i == 14) chk("stall_14", 32'(bus.stall_cnt), 32'd14);
            if (i == 15) chk("stall_15", 32'(bus.stall_cnt), 32'd15);
            av = {11'h0, 11'h0, 11'(11'h200 + i), 11'(11'h300 + i)};
`ifdef FONT_ARB_RR_EN
            eg = (i % 2 == 0) ? 4'b0001 : 4'b0010;
`else
            eg = 4'b0001;
`endif
            cyc(4'b0011, av, eg, 1'b0);
        end
        chk("stall_saturated", 32'(bus.stall_cnt), 32'hF);
        av = {11'h0, 11'h0, 11'h2AA, 11'h155};
        cyc(4'b0011, av, 4'b0001, 1'b1);
        chk("stall_clr_priority", 32'(bus.stall_cnt), 32'h0);
        idle();

        // Reset while a read is in flight.
        av = {11'h7A1, 11'h7A2, 11'h7A3, 11'h7A4};
`ifdef FONT_ARB_RR_EN
        eg = 4'b0010;
`else
        eg = 4'b0001;
`endif
        cyc(4'b1111, av, eg, 1'b0);
        bus.req = 4'b1111;
        reset   = 1'b1;
        sb_q.delete();
        last_addr = '0;
        #1;
        chk("midrst_gnt", 32'(bus.gnt), 32'h0);
        chk("midrst_rd_valid", 32'(bus.rd_valid), 32'h0);
        chk("midrst_stall_cnt", 32'(bus.stall_cnt), 32'h0);
        chk("midrst_rom_addr", 32'(bus.rom_addr), 32'h0);
        @(posedge clk);
        #1;
        bus.req = 4'b0000;
        reset   = 1'b0;
        #1;
        chk("post_rst_rd_valid0", 32'(bus.rd_valid), 32'h0);
        @(posedge clk);
        #1;
        chk("post_rst_rd_valid1", 32'(bus.rd_valid), 32'h0);
        idle();
        av = {11'h7FF, 11'h0, 11'h0, 11'h0};
        cyc(4'b1000, av, 4'b1000, 1'b0);
        idle();
        idle();
        chk("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
